seg_fault_handler: RTL and testbench
====================================

# seg_fault_handler

Responder for the segment-violation exception raised by the address checker. On each qualified `segment` assertion it captures the faulting address and the faulting PC, then requests a trap from the control unit. After the request is acknowledged it redirects fetch to a fixed handler vector, and on `eret` it returns fetch to the saved PC. It sits between the address checker/memory stage and the control unit's PC-select logic.

## Interface
- `VECTOR`, default 16'h0040: handler entry address driven on `target_pc` during redirect.
- `WIDTH`, default 16: address/PC width.
- `CLK` in 1: system clock, rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `segment` in 1: violation flag from the address checker (combinational).
- `MemAccess` in 1: current instruction performs a data-memory access; qualifies `segment`.
- `Addr` in WIDTH: address that was checked.
- `PC` in WIDTH: PC of the instruction in the memory stage.
- `exc_ack` in 1: control unit accepts the trap request.
- `eret` in 1: handler executes exception return.
- `exc_req` out 1: trap request, level, held until acknowledged.
- `redirect` out 1: one-cycle pulse; control loads `target_pc` into PC.
- `target_pc` out WIDTH: `VECTOR` during the redirect pulse, `epc` during the resume pulse, otherwise 0.
- `epc` out WIDTH: captured faulting PC.
- `bad_addr` out WIDTH: captured faulting address.
- `in_handler` out 1: high while the trap is being serviced.
- `double_fault` out 1: sticky; a fault occurred inside the handler.

## Operation
- fault = `segment & MemAccess`.
- States: IDLE, REQ, HANDLER, HALT.
- IDLE: fault at an edge captures `epc`←`PC` and `bad_addr`←`Addr`, then goes to REQ. Otherwise hold.
- REQ: `exc_req`=1. `exc_ack` at an edge goes to HANDLER and fires `redirect` with `target_pc`=`VECTOR`. Further faults are ignored; the first capture is preserved. `eret` is ignored.
- HANDLER: `in_handler`=1.
  - `eret` at an edge goes to IDLE and fires `redirect` with `target_pc`=`epc`.
  - fault at an edge goes to HALT and sets `double_fault`=1.
  - fault and `eret` on the same edge: fault wins, go to HALT.
- HALT: terminal. `exc_req`=0, `in_handler`=0, `double_fault`=1. Only reset exits.
- `epc` and `bad_addr` are written only on the IDLE→REQ transition. They keep their values after return.

## Timing
- All outputs are registered. Nothing is combinational from inputs to outputs.
- Reset (any time, including mid-trap): state IDLE. `exc_req`, `redirect`, `in_handler`, `double_fault` = 0. `target_pc`, `epc`, `bad_addr` = 0. Fault count = 0.
- Fault sampled at edge N gives `exc_req`=1 from N until the edge where `exc_ack` is sampled.
- `exc_ack` sampled at edge M gives `redirect`=1 and `in_handler`=1 for cycle M→M+1. `redirect` drops at M+1.
- `exc_ack` already high when REQ is entered is taken at the next edge, so minimum request width is 1 cycle.
- `eret` sampled at edge K gives `redirect`=1 with `target_pc`=`epc`, and `in_handler`=0, for cycle K→K+1.
- A fault in the same cycle as the resume pulse (state already IDLE) starts a new trap normally.
- Back-to-back trap after return is allowed. Minimum spacing: fault, REQ, HANDLER, IDLE is 3 edges.

## Configuration
- `SEG_FAULT_COUNT_EN` defined:
  - Adds output `fault_count` out 8.
  - Counts IDLE→REQ transitions plus the HANDLER→HALT transition.
  - Saturates at 8'hFF and never wraps.
  - Reset value 0.
- Not defined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- Reset: hold `Reset`=0 mid-REQ → all outputs 0. Release → state IDLE, `exc_req`=0.
- Basic trap:
  - `segment`=1, `MemAccess`=1, `Addr`=16'hC3FF, `PC`=16'h0122 → next cycle `exc_req`=1, `bad_addr`=C3FF, `epc`=0122.
  - `exc_ack` 2 cycles later → one-cycle `redirect` with `target_pc`=0040, then `in_handler`=1.
  - `eret` → `redirect` with `target_pc`=0122, `in_handler`=0.
- Unqualified flag: `segment`=1 with `MemAccess`=0 for 5 cycles → `exc_req` stays 0, `epc`/`bad_addr` unchanged.
- Fault while pending: second fault with `Addr`=16'h0FFF during REQ → `bad_addr` stays C3FF.
- Double fault: fault and `eret` on the same edge in HANDLER → `double_fault`=1, `in_handler`=0, no `redirect`. Stays stuck until reset.
- With `SEG_FAULT_COUNT_EN`: 300 trap/return cycles → `fault_count`=8'hFF, no wrap.

Source files
------------

// File: rtl/seg_fault_handler.sv
// -----------------------------------------------------------------------------
// seg_fault_handler
//
// Responds to the segment-violation exception from the address checker.
// A qualified fault (i_segment & i_mem_access) seen while idle captures the
// faulting PC and address. The block then raises a level trap request to the
// control unit. Once that request is acknowledged, fetch is redirected to the
// fixed handler vector. On exception return, fetch goes back to the saved PC.
// A fault taken while the handler is running is a double fault: the block
// locks up in HALT until reset.
//
// Optional feature macro: SEG_FAULT_COUNT_EN
//   When defined, adds o_fault_count, a saturating 8-bit count of trap entries
//   (IDLE->REQ) plus double-fault entries (HANDLER->HALT).
//
// Parameters
//   WIDTH          address / PC width
//   VECTOR         handler entry address driven during the entry redirect
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_segment      violation flag from the address checker
//   i_mem_access   current instruction accesses data memory (qualifies fault)
//   i_addr         address that was checked
//   i_pc           PC of the instruction in the memory stage
//   i_exc_ack      control unit accepts the trap request
//   i_eret         handler executes exception return
//   o_exc_req      trap request, held until acknowledged
//   o_redirect     one-cycle pulse: load o_target_pc into PC
//   o_target_pc    VECTOR on entry pulse, o_epc on resume pulse, else 0
//   o_epc          captured faulting PC
//   o_bad_addr     captured faulting address
//   o_in_handler   trap is being serviced
//   o_double_fault sticky: fault occurred inside the handler
//   o_fault_count  (SEG_FAULT_COUNT_EN only) saturating fault counter
// -----------------------------------------------------------------------------
module seg_fault_handler #(
   parameter int               WIDTH  = 16,
   parameter logic [WIDTH-1:0] VECTOR = 16'h0040
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_segment,
   input  logic             i_mem_access,
   input  logic [WIDTH-1:0] i_addr,
   input  logic [WIDTH-1:0] i_pc,
   input  logic             i_exc_ack,
   input  logic             i_eret,
   output logic             o_exc_req,
   output logic             o_redirect,
   output logic [WIDTH-1:0] o_target_pc,
   output logic [WIDTH-1:0] o_epc,
   output logic [WIDTH-1:0] o_bad_addr,
   output logic             o_in_handler,
`ifdef SEG_FAULT_COUNT_EN
   output logic [7:0]       o_fault_count,
`endif
   output logic             o_double_fault
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_HANDLER = 2'd2,
      S_HALT    = 2'd3
   } state_t;

   state_t           r_state;
   logic             r_exc_req;
   logic             r_redirect;
   logic [WIDTH-1:0] r_target_pc;
   logic [WIDTH-1:0] r_epc;
   logic [WIDTH-1:0] r_bad_addr;
   logic             r_in_handler;
   logic             r_double_fault;
   logic             w_fault;

   // A violation only matters when the instruction really touches data memory.
   always_comb begin
      w_fault = i_segment & i_mem_access;
   end

   // Trap state machine; every output is produced directly as a register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state        <= S_IDLE;
         r_exc_req      <= 1'b0;
         r_redirect     <= 1'b0;
         r_target_pc    <= {WIDTH{1'b0}};
         r_epc          <= {WIDTH{1'b0}};
         r_bad_addr     <= {WIDTH{1'b0}};
         r_in_handler   <= 1'b0;
         r_double_fault <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // A fault here may land in the resume-pulse cycle; that still
               // starts a fresh trap, so the pulse is simply dropped.
               r_redirect   <= 1'b0;
               r_target_pc  <= {WIDTH{1'b0}};
               r_in_handler <= 1'b0;
               if (w_fault) begin
                  r_state    <= S_REQ;
                  r_exc_req  <= 1'b1;
                  r_epc      <= i_pc;
                  r_bad_addr <= i_addr;
               end else begin
                  r_exc_req  <= 1'b0;
               end
            end
            S_REQ: begin
               // Later faults and eret are ignored so the first capture is kept.
               if (i_exc_ack) begin
                  r_state      <= S_HANDLER;
                  r_exc_req    <= 1'b0;
                  r_redirect   <= 1'b1;
                  r_target_pc  <= VECTOR;
                  r_in_handler <= 1'b1;
               end else begin
                  r_exc_req    <= 1'b1;
                  r_redirect   <= 1'b0;
                  r_target_pc  <= {WIDTH{1'b0}};
                  r_in_handler <= 1'b0;
               end
            end
            S_HANDLER: begin
               r_exc_req <= 1'b0;
               // Fault has priority over eret: a handler that faults must not resume.
               if (w_fault) begin
                  r_state        <= S_HALT;
                  r_redirect     <= 1'b0;
                  r_target_pc    <= {WIDTH{1'b0}};
                  r_in_handler   <= 1'b0;
                  r_double_fault <= 1'b1;
               end else if (i_eret) begin
                  r_state      <= S_IDLE;
                  r_redirect   <= 1'b1;
                  r_target_pc  <= r_epc;
                  r_in_handler <= 1'b0;
               end else begin
                  r_redirect   <= 1'b0;
                  r_target_pc  <= {WIDTH{1'b0}};
                  r_in_handler <= 1'b1;
               end
            end
            S_HALT: begin
               r_exc_req      <= 1'b0;
               r_redirect     <= 1'b0;
               r_target_pc    <= {WIDTH{1'b0}};
               r_in_handler   <= 1'b0;
               r_double_fault <= 1'b1;
            end
            default: begin
               // Unreachable encoding: fall back to a quiet idle state.
               r_state        <= S_IDLE;
               r_exc_req      <= 1'b0;
               r_redirect     <= 1'b0;
               r_target_pc    <= {WIDTH{1'b0}};
               r_in_handler   <= 1'b0;
               r_double_fault <= 1'b0;
            end
         endcase
      end
   end

`ifdef SEG_FAULT_COUNT_EN
   logic [7:0] r_fault_count;
   logic       w_count_inc;

   // Both counted transitions are "fault while in IDLE or HANDLER".
   always_comb begin
      w_count_inc = w_fault & ((r_state == S_IDLE) | (r_state == S_HANDLER));
   end

   // Saturating fault counter; it holds at 8'hFF instead of wrapping.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_fault_count <= 8'd0;
      end else if (w_count_inc && (r_fault_count != 8'hFF)) begin
         r_fault_count <= r_fault_count + 8'd1;
      end else begin
         r_fault_count <= r_fault_count;
      end
   end

   assign o_fault_count = r_fault_count;
`endif

   assign o_exc_req      = r_exc_req;
   assign o_redirect     = r_redirect;
   assign o_target_pc    = r_target_pc;
   assign o_epc          = r_epc;
   assign o_bad_addr     = r_bad_addr;
   assign o_in_handler   = r_in_handler;
   assign o_double_fault = r_double_fault;

endmodule

// File: tb/tb_seg_fault_handler.sv
// -----------------------------------------------------------------------------
// tb_seg_fault_handler
//
// Self-checking bench for seg_fault_handler (WIDTH=16, VECTOR=16'h0040).
// It runs in three parts:
//   1. A directed vector table covering the basic trap flow and its corners.
//   2. Hand-written reset and saturation sequences.
//   3. Randomized traffic checked against a behavioural model of the trap rules.
// -----------------------------------------------------------------------------
module tb_seg_fault_handler;

   localparam logic [15:0] VEC = 16'h0040;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        seg = 1'b0, mem = 1'b0, ack = 1'b0, eret = 1'b0;
   logic [15:0] addr = 16'h0, pc = 16'h0;
   logic        exc_req, redirect, in_handler, dbl;
   logic [15:0] tgt, epc, bad;
`ifdef SEG_FAULT_COUNT_EN
   logic [7:0]  fcnt;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   seg_fault_handler #(.WIDTH(16), .VECTOR(VEC)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_segment      (seg),
      .i_mem_access   (mem),
      .i_addr         (addr),
      .i_pc           (pc),
      .i_exc_ack      (ack),
      .i_eret         (eret),
      .o_exc_req      (exc_req),
      .o_redirect     (redirect),
      .o_target_pc    (tgt),
      .o_epc          (epc),
      .o_bad_addr     (bad),
      .o_in_handler   (in_handler),
`ifdef SEG_FAULT_COUNT_EN
      .o_fault_count  (fcnt),
`endif
      .o_double_fault (dbl)
   );

   // ---------------- behavioural model ----------------
   // The model tracks what the trap protocol is doing in terms of a few
   // facts: a request is pending, the handler is running, the core is halted.
   bit          m_pend, m_serv, m_halt;
   logic        m_redir;
   logic [15:0] m_tgt, m_epc, m_bad;
   int          m_cnt;

   task automatic model_reset();
      m_pend = 1'b0; m_serv = 1'b0; m_halt = 1'b0;
      m_redir = 1'b0; m_tgt = 16'h0; m_epc = 16'h0; m_bad = 16'h0;
      m_cnt = 0;
   endtask

   task automatic model_step(input logic s, input logic m, input logic a,
                             input logic e, input logic [15:0] ad, input logic [15:0] p);
      bit f;
      f = s & m;
      m_redir = 1'b0;
      m_tgt   = 16'h0;
      if (m_halt) begin
         // locked until reset
      end else if (m_pend) begin
         if (a) begin
            m_pend = 1'b0; m_serv = 1'b1; m_redir = 1'b1; m_tgt = VEC;
         end
      end else if (m_serv) begin
         if (f) begin
            m_serv = 1'b0; m_halt = 1'b1;
            if (m_cnt < 255) m_cnt = m_cnt + 1;
         end else if (e) begin
            m_serv = 1'b0; m_redir = 1'b1; m_tgt = m_epc;
         end
      end else if (f) begin
         m_pend = 1'b1; m_epc = p; m_bad = ad;
         if (m_cnt < 255) m_cnt = m_cnt + 1;
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_model(input string pfx);
      chk({pfx, ".exc_req"},    16'(exc_req),    16'(m_pend));
      chk({pfx, ".redirect"},   16'(redirect),   16'(m_redir));
      chk({pfx, ".target_pc"},  tgt,             m_tgt);
      chk({pfx, ".epc"},        epc,             m_epc);
      chk({pfx, ".bad_addr"},   bad,             m_bad);
      chk({pfx, ".in_handler"}, 16'(in_handler), 16'(m_serv));
      chk({pfx, ".double"},     16'(dbl),        16'(m_halt));
`ifdef SEG_FAULT_COUNT_EN
      chk({pfx, ".fault_count"}, 16'(fcnt), 16'(m_cnt));
`endif
   endtask

   // Drive one set of inputs, clock it in, and advance the model.
   task automatic step(input logic s, input logic m, input logic a, input logic e,
                       input logic [15:0] ad, input logic [15:0] p);
      seg = s; mem = m; ack = a; eret = e; addr = ad; pc = p;
      @(posedge clk);
      #1;
      model_step(s, m, a, e, ad, p);
   endtask

   // Assert reset mid-cycle, check the asynchronous clear, release before the next edge.
   task automatic do_reset(input string pfx);
      rst_n = 1'b0;
      seg = 1'b0; mem = 1'b0; ack = 1'b0; eret = 1'b0;
      #1;
      model_reset();
      check_model(pfx);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // ---------------- directed table ----------------
   typedef struct packed {
      logic        seg, mem, ack, eret;
      logic [15:0] addr, pc;
      logic        xreq, redir, inh, dbl;
      logic [15:0] tgt, epc, bad;
   } vec_t;

   function automatic vec_t mk(input logic s, input logic m, input logic a, input logic e,
                               input logic [15:0] ad, input logic [15:0] p,
                               input logic xr, input logic rd, input logic ih, input logic df,
                               input logic [15:0] t, input logic [15:0] ep, input logic [15:0] bd);
      vec_t v;
      v.seg = s; v.mem = m; v.ack = a; v.eret = e; v.addr = ad; v.pc = p;
      v.xreq = xr; v.redir = rd; v.inh = ih; v.dbl = df;
      v.tgt = t; v.epc = ep; v.bad = bd;
      return v;
   endfunction

   vec_t tbl [19];

   initial begin
      //            seg mem ack eret addr      pc        req rd  inh dbl tgt       epc       bad
      tbl[0]  = mk(1, 1, 0, 0, 16'hC3FF, 16'h0122, 1, 0, 0, 0, 16'h0000, 16'h0122, 16'hC3FF); // basic fault
      tbl[1]  = mk(1, 1, 0, 0, 16'h0FFF, 16'h0200, 1, 0, 0, 0, 16'h0000, 16'h0122, 16'hC3FF); // fault while pending
      tbl[2]  = mk(0, 0, 0, 1, 16'h0000, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'h0122, 16'hC3FF); // eret ignored in REQ
      tbl[3]  = mk(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 1, 1, 0, 16'h0040, 16'h0122, 16'hC3FF); // ack -> vector
      tbl[4]  = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h0000, 16'h0122, 16'hC3FF); // in handler
      tbl[5]  = mk(0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 0, 0, 16'h0122, 16'h0122, 16'hC3FF); // eret -> epc
      tbl[6]  = mk(1, 0, 0, 0, 16'h1111, 16'h2222, 0, 0, 0, 0, 16'h0000, 16'h0122, 16'hC3FF); // unqualified x5
      tbl[7]  = tbl[6];
      tbl[8]  = tbl[6];
      tbl[9]  = tbl[6];
      tbl[10] = tbl[6];
      tbl[11] = mk(1, 1, 1, 0, 16'h0AAA, 16'h0300, 1, 0, 0, 0, 16'h0000, 16'h0300, 16'h0AAA); // ack high on entry
      tbl[12] = mk(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 1, 1, 0, 16'h0040, 16'h0300, 16'h0AAA); // 1-cycle request
      tbl[13] = mk(0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 0, 0, 16'h0300, 16'h0300, 16'h0AAA); // resume
      tbl[14] = mk(1, 1, 0, 0, 16'h0BBB, 16'h0400, 1, 0, 0, 0, 16'h0000, 16'h0400, 16'h0BBB); // fault in resume cycle
      tbl[15] = mk(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 1, 1, 0, 16'h0040, 16'h0400, 16'h0BBB);
      tbl[16] = mk(1, 1, 0, 1, 16'h0CCC, 16'h0500, 0, 0, 0, 1, 16'h0000, 16'h0400, 16'h0BBB); // fault+eret -> HALT
      tbl[17] = mk(0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0000, 16'h0400, 16'h0BBB); // stuck
      tbl[18] = mk(1, 1, 1, 0, 16'h0DDD, 16'h0600, 0, 0, 0, 1, 16'h0000, 16'h0400, 16'h0BBB); // stuck

      model_reset();
      #12;
      do_reset("reset0");

      for (int i = 0; i < 19; i++) begin
         string nm;
         nm = $sformatf("tbl%0d", i);
         step(tbl[i].seg, tbl[i].mem, tbl[i].ack, tbl[i].eret, tbl[i].addr, tbl[i].pc);
         chk({nm, ".exc_req"},    16'(exc_req),    16'(tbl[i].xreq));
         chk({nm, ".redirect"},   16'(redirect),   16'(tbl[i].redir));
         chk({nm, ".target_pc"},  tgt,             tbl[i].tgt);
         chk({nm, ".epc"},        epc,             tbl[i].epc);
         chk({nm, ".bad_addr"},   bad,             tbl[i].bad);
         chk({nm, ".in_handler"}, 16'(in_handler), 16'(tbl[i].inh));
         chk({nm, ".double"},     16'(dbl),        16'(tbl[i].dbl));
      end

      // Reset out of HALT, then reset again in the middle of a pending request.
      do_reset("reset_halt");
      step(1'b1, 1'b1, 1'b0, 1'b0, 16'h5A5A, 16'h0777);
      check_model("pre_midreq");
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      check_model("midreq");
      do_reset("reset_midreq");
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      chk("post_reset.exc_req", 16'(exc_req), 16'h0000);
      check_model("post_reset");

`ifdef SEG_FAULT_COUNT_EN
      // 300 complete trap/return cycles must saturate the counter at 8'hFF.
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0, 16'(i), 16'(i + 1));
         step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
         step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
      end
      chk("count_saturate", 16'(fcnt), 16'h00FF);
      check_model("count_end");
      do_reset("reset_count");
`endif

      // Randomized traffic checked against the model.
      for (int i = 0; i < 3000; i++) begin
         if ((m_halt && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 299) == 0)) begin
            do_reset($sformatf("rnd_reset%0d", i));
         end else begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                 16'($urandom), 16'($urandom));
            check_model($sformatf("rnd%0d", i));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
